stt_branch_ptr_ctrl: RTL

STT_BRANCH_PTR_CTRL -- requirements
Module: stt_branch_ptr_ctrl

---
 rtl/stt_pkg.sv | 28 ++
 rtl/stt_popcount.sv | 24 ++
 rtl/stt_branch_ptr_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/stt_pkg.sv
`default_nettype none
// ============================================================================
// Module : stt_pkg
// Brief  : Shared types and width helpers for the branch-epoch pointer ring.
// Rev    : 1.0  initial release
// ============================================================================
package stt_pkg;

  localparam int unsigned DEFAULT_NUM_ROB = 512;

  // Epoch pointer width for a power-of-two ring; never narrower than 1 bit.
  function automatic int unsigned yrot_width(input int unsigned num_rob);
    return (num_rob > 1) ? $clog2(num_rob) : 1;
  endfunction

  localparam int unsigned DEFAULT_YROT_WIDTH = yrot_width(DEFAULT_NUM_ROB);

  // Epoch pointer for the default ring size.
  typedef logic [DEFAULT_YROT_WIDTH-1:0] epoch_ptr_t;

  // Controller FSM: normal renaming, or the post-squash blackout.
  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/stt_popcount.sv
`default_nettype none
// ============================================================================
// Module : stt_popcount
// Brief  : Combinational population count of a WIDTH-bit mask.
// Rev    : 1.0  initial release
// ============================================================================
module stt_popcount #(
  parameter int WIDTH     = 10,
  parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     mask_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  // Sum of set bits; a simple adder chain is plenty for a rename-width mask.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CNT_WIDTH'(mask_i[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/stt_branch_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module : stt_branch_ptr_ctrl
// Brief  : Branch-epoch ring head/tail/occupancy tracker with rename
//          back-pressure, in-order resolve and mispredict squash recovery.
// Rev    : 1.0  initial release
// ============================================================================
module stt_branch_ptr_ctrl
  import stt_pkg::*;
#(
  parameter int NUM_DECODE     = 10,
  parameter int NUM_ROB        = 512,
  parameter int YROT_WIDTH     = yrot_width(NUM_ROB),
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             grp_valid,
  input  logic [NUM_DECODE-1:0]            grp_branch_mask,
  output logic                             grp_ready,
  input  logic                             resolve_valid,
  input  logic [$clog2(NUM_DECODE+1)-1:0]  resolve_count,
  input  logic                             squash_valid,
  input  logic [YROT_WIDTH-1:0]            squash_tail,
  output logic [2*YROT_WIDTH-1:0]          branch_ptr,
  output logic [YROT_WIDTH:0]              occupancy,
  output logic                             recovering,
  output logic                             err_underflow
);

  localparam int PCW = $clog2(NUM_DECODE + 1);
  localparam int CW  = $clog2(RECOVER_CYCLES + 1);
  localparam int YW  = YROT_WIDTH;

  localparam logic [YW:0]   C_ROB_SIZE     = (YW+1)'(NUM_ROB);
  localparam logic [CW-1:0] C_RECOVER_LOAD = CW'(RECOVER_CYCLES);

  // Registered state
  logic [YW-1:0] head_q, head_d;
  logic [YW-1:0] tail_q, tail_d;
  logic [YW:0]   occ_q,  occ_d;
  logic          err_q,  err_d;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          recovering_q;

  // Combinational helpers
  logic [PCW-1:0] w_pop;
  logic [YW:0]    w_pop_ext;
  logic [YW:0]    w_res_ext;
  logic           w_res_ok;
  logic [YW:0]    w_res_amt;
  logic [YW:0]    w_fire_amt;
  logic           w_fire;
  logic [YW-1:0]  w_head_new;

  stt_popcount #(
    .WIDTH     (NUM_DECODE),
    .CNT_WIDTH (PCW)
  ) u_popcount (
    .mask_i  (grp_branch_mask),
    .count_o (w_pop)
  );

  assign w_pop_ext = (YW+1)'(w_pop);
  assign w_res_ext = (YW+1)'(resolve_count);

  // A resolve retiring more branches than are live is dropped entirely.
  assign w_res_ok  = resolve_valid && (w_res_ext <= occ_q);
  assign w_res_amt = w_res_ok ? w_res_ext : '0;

  // Ready only looks at registered state, the mask and squash; reset forces 0.
  assign grp_ready = !rst && (state_q == ST_RUN) && !squash_valid &&
                     ((C_ROB_SIZE - occ_q) >= w_pop_ext);

  assign w_fire     = grp_valid && grp_ready;
  assign w_fire_amt = w_fire ? w_pop_ext : '0;

  // Head after this cycle's resolve; squash recomputes occupancy against it.
  assign w_head_new = YW'({1'b0, head_q} + w_res_amt);

  // Next-state for pointers, occupancy and the sticky underflow flag.
  always_comb begin
    head_d = w_head_new;
    tail_d = tail_q;
    occ_d  = occ_q;
    err_d  = err_q | (resolve_valid && !w_res_ok);
    if (squash_valid) begin
      tail_d = squash_tail;
      occ_d  = {1'b0, squash_tail - w_head_new};
    end else begin
      tail_d = YW'({1'b0, tail_q} + w_fire_amt);
      occ_d  = occ_q - w_res_amt + w_fire_amt;
    end
  end

  // Pointer, occupancy and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      err_q  <= err_d;
    end
  end

  // RUN/RECOVER FSM: squash (re)loads the blackout counter from either state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      recovering_q <= 1'b0;
    end else if (squash_valid) begin
      state_q      <= ST_RECOVER;
      cnt_q        <= C_RECOVER_LOAD;
      recovering_q <= 1'b1;
    end else if (state_q == ST_RECOVER) begin
      if (cnt_q <= CW'(1)) begin
        state_q      <= ST_RUN;
        cnt_q        <= '0;
        recovering_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign branch_ptr    = {head_q, tail_q};
  assign occupancy     = occ_q;
  assign recovering    = recovering_q;
  assign err_underflow = err_q;

endmodule
`default_nettype wire
